// File: rtl/note_sequencer.sv
// note_sequencer: record/playback of live notecodes with tick-quantised durations
module note_sequencer #(
  parameter int DEPTH    = 32,
  parameter int TICK_DIV = 50000,
  parameter int DUR_W    = 8
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic [4:0]               live_note,
  input  logic                     rec,
  input  logic                     play,
  input  logic                     stop,
  output logic [4:0]               note_out,
  output logic [1:0]               mode,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RECORD = 2'b01;
  localparam logic [1:0] PLAY   = 2'b10;
  logic [4+DUR_W:0]  mem [DEPTH];
  logic [TW-1:0]     tcnt;
  logic              tick, we, split;
  logic [4:0]        cur, pnote, n_cur, n_pnote;
  logic [DUR_W-1:0]  dur, rem, wd, n_dur, n_rem;
  logic [AW-1:0]     idx, n_idx;
  logic [CW-1:0]     n_count;
  logic [1:0]        n_mode;
  assign tick  = tcnt == TW'(TICK_DIV - 1);
  // wd is the duration as of this edge, so a tick coinciding with a change or flush is counted
  assign wd    = dur + DUR_W'(tick);
  assign split = tick && &wd;
  assign full  = count == CW'(DEPTH);
  always_comb begin
    n_mode  = mode;
    n_cur   = cur;
    n_dur   = dur;
    n_idx   = idx;
    n_rem   = rem;
    n_pnote = pnote;
    n_count = count;
    we      = 1'b0;
    case (mode)
      IDLE:
        if (!stop && rec) begin
          n_mode  = RECORD;
          n_count = '0;
          n_cur   = live_note;
          n_dur   = '0;
        end else if (!stop && play && |count) begin
          n_mode           = PLAY;
          n_idx            = '0;
          {n_pnote, n_rem} = mem[0];
        end
      RECORD: begin
        we      = (stop || rec) ? |wd : split || (live_note != cur && |wd);
        n_cur   = live_note;
        n_dur   = we ? '0 : wd;
        n_count = count + CW'(we);
        n_mode  = (stop || rec || n_count == CW'(DEPTH)) ? IDLE : RECORD;
      end
      PLAY:
        if (stop) n_mode = IDLE;
        else if (tick) begin
          n_rem = rem - 1'b1;
          if (rem == DUR_W'(1)) begin
            if ({1'b0, idx} + 1'b1 < count) begin
              n_idx            = idx + 1'b1;
              {n_pnote, n_rem} = mem[idx + 1'b1];
            end else n_mode = IDLE;
          end
        end
      default: n_mode = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      mode     <= IDLE;
      note_out <= '0;
      count    <= '0;
      tcnt     <= '0;
      cur      <= '0;
      dur      <= '0;
      idx      <= '0;
      rem      <= '0;
      pnote    <= '0;
    end else begin
      mode     <= n_mode;
      count    <= n_count;
      cur      <= n_cur;
      dur      <= n_dur;
      idx      <= n_idx;
      rem      <= n_rem;
      pnote    <= n_pnote;
      tcnt     <= (n_mode != mode || tick) ? '0 : tcnt + 1'b1;
      note_out <= (n_mode == PLAY && live_note == 5'd0) ? n_pnote : live_note;
    end
  always_ff @(posedge clk_in)
    if (we) mem[count[AW-1:0]] <= {cur, wd};
endmodule
